instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Upstream feeder for the 9-bit processor `proc`. It holds a small program memory and a program counter.
- It drives `proc`'s `Instruction` and `Run` inputs and consumes `proc`'s `Done`.
- It issues one instruction at a time, presents the immediate word for `mvi`, and waits for `Done` before advancing.
- It replaces hand-driven `Run`/`Instruction` stimulus in system-level runs.

Parameters:
- ADDR_W, 5: program memory address width; depth = 2**ADDR_W words of 9 bits.
- TIMEOUT, 15: maximum cycles to wait for `Done` after issue before flagging an error.

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Start  in  1  single-cycle pulse; begins execution at address 0 when idle.
- Step  in  1  single-step advance pulse (used only with SEQ_STEP_EN).
- WrEn  in  1  program memory write strobe; accepted only when not Busy.
- WrAddr  in  ADDR_W  program memory write address.
- WrData  in  9  program memory write data.
- Done  in  1  from `proc`; instruction complete.
- Instruction  out  9  to `proc` Instruction input.
- Run  out  1  to `proc` Run input.
- PC  out  ADDR_W  current program counter.
- Busy  out  1  high from Start until halt or error.
- Error  out  1  sticky; set on Done timeout.

Behaviour:
- Instruction format: III XXX YYY. Opcodes: 000 mv, 001 mvi (two words), 010 add, 011 sub, 111 HALT (not issued to proc); 100-110 are issued as-is.
- Memory: register array with asynchronous read. Write is synchronous when WrEn=1 and Busy=0; WrEn while Busy is ignored. Contents are not cleared by reset.
- Reset values: Instruction=0, Run=0, PC=0, Busy=0, Error=0; state IDLE; timeout counter 0.
- States:
  - IDLE: outputs 0. Start → ISSUE, PC=0, Busy=1, Error=0.
  - ISSUE, 1 cycle: Instruction=mem[PC]. If opcode=111 → HALT without raising Run. Otherwise Run=1; next state IMM if opcode=001, else WAIT.
  - IMM, 1 cycle: Run=0, Instruction=mem[PC+1] (PC+1 wraps modulo depth). Done sampled here; if Done=1 → ADV, else → WAIT.
  - WAIT: Run=0, Instruction=0. Count cycles. Done=1 → ADV. If count reaches TIMEOUT without Done → ERR.
  - ADV, 1 cycle: PC += 1, or += 2 for mvi, modulo depth; clear counter → ISSUE.
  - HALT: Busy=0; PC holds the HALT address; → IDLE next cycle.
  - ERR: Error=1, Busy=0, Run=0; → IDLE. Error stays high until the next Start.
- Latency: Run rises exactly one cycle after Start. Consecutive instructions have exactly 2 cycles from Done=1 to the next Run=1 (ADV, then ISSUE).
- Done arriving in ISSUE, IDLE, ADV or HALT is ignored.
- Start while Busy is ignored.
- PC wrap: reaching the last address without HALT wraps to 0 and continues.
- Asynchronous reset mid-operation returns immediately to reset values; Run drops without waiting for Done.
- Run is never high for more than one consecutive cycle.

Optional Feature:
- Macro: SEQ_STEP_EN.
- Defined: ADV waits for a Step pulse before entering ISSUE, holding PC and Busy=1. A Step arriving in any other state is dropped.
- Undefined: the Step input is ignored and ADV proceeds unconditionally.

Test Plan:
- Load [0]=001000000 (mvi R0), [1]=000000101, [2]=111000000; Start; proc Done during IMM.
  → Run pulses once with Instruction=001000000; next cycle Instruction=000000101, Run=0; PC goes 0→2; HALT with Busy low; Error=0.
- Load mv R1,R0 / add R0,R1 / sub R0,R0 / HALT; Done asserted 1, 2 and 3 cycles after the respective Run.
  → exactly 3 Run pulses; gap from each Done to the next Run = 2 cycles; PC ends at 3.
- Load add R0,R1 with Done never asserted.
  → after TIMEOUT=15 WAIT cycles Error=1, Busy=0; the next Start clears Error.
- While Busy, pulse WrEn at address 0 with 111000000 and pulse Start.
  → both ignored; program completes unchanged; a reread after halt shows the original word.
- Deassert Resetn during WAIT.
  → Run=0, PC=0, Busy=0 in the same cycle without a clock edge; a Start after release reruns from address 0.
- With SEQ_STEP_EN defined and a program of 2 instructions + HALT.
  → after the first Done, PC stays 0 and Run stays low until Step; Step pulse → PC=1 and the next Run 1 cycle later.

Source files
------------

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Upstream feeder for the 9-bit processor `proc`. Holds a small program memory
// and a program counter, issues one instruction at a time on Instruction/Run,
// presents the immediate word of an mvi on the following cycle, and waits for
// proc's Done before advancing. An opcode of 111 halts the sequence without
// being issued. A missing Done within TIMEOUT wait cycles raises a sticky Error.
//
// Optional build macro: SEQ_STEP_EN
//   defined   - the advance state holds until a Step pulse (single-step mode)
//   undefined - Step is ignored and the sequencer free-runs
//
// Ports:
//   Clock       in   system clock, all state on rising edge
//   Resetn      in   asynchronous active-low reset
//   Start       in   pulse, begins execution at address 0 when idle
//   Step        in   single-step advance pulse (SEQ_STEP_EN builds only)
//   WrEn        in   program memory write strobe, ignored while Busy
//   WrAddr      in   program memory write address
//   WrData      in   program memory write data
//   Done        in   from proc, instruction complete
//   Instruction out  to proc Instruction input
//   Run         out  to proc Run input
//   PC          out  current program counter
//   Busy        out  high from Start until halt or error
//   Error       out  sticky Done-timeout flag, cleared by the next Start
//   dbg_state   out  FSM state encoding for observation
//
// Handshake: Run is a one-cycle issue strobe qualifying Instruction. proc
// answers with a Done pulse; Done is only honoured in IMM (the cycle after an
// mvi issue) and in WAIT. In every other state Done is dropped, and the next
// Run never rises before the Done of the previous instruction was accepted.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Step,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [8:0]        WrData,
  input  logic              Done,
  output logic [8:0]        Instruction,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Error,
  output logic [2:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_IMM   = 3'd2,
    S_WAIT  = 3'd3,
    S_ADV   = 3'd4,
    S_HALT  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              error_q, error_d;

  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] pc_plus1;
  logic [8:0]        cur_word;
  logic [8:0]        imm_word;
  logic              cur_is_mvi;
  logic              advance;

  // Program memory: no reset, so a loaded program survives a reset pulse.
  always_ff @(posedge Clock) begin
    if (WrEn && !Busy) begin
      mem[WrAddr] <= WrData;
    end
  end

  assign pc_plus1   = pc_q + ADDR_W'(1);
  assign cur_word   = mem[pc_q];
  assign imm_word   = mem[pc_plus1];
  assign cur_is_mvi = (cur_word[8:6] == OP_MVI);

`ifdef SEQ_STEP_EN
  assign advance = Step;
`else
  logic unused_step;
  assign unused_step = Step;
  assign advance     = 1'b1;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    Instruction = '0;
    Run         = 1'b0;
    Busy        = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (Start) begin
          state_d = S_ISSUE;
          pc_d    = '0;
          error_d = 1'b0;
        end
      end
      S_ISSUE: begin
        Busy        = 1'b1;
        Instruction = cur_word;
        cnt_d       = '0;
        if (cur_word[8:6] == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          Run     = 1'b1;
          state_d = cur_is_mvi ? S_IMM : S_WAIT;
        end
      end
      S_IMM: begin
        // proc may finish an mvi while its immediate is still on the bus.
        Busy        = 1'b1;
        Instruction = imm_word;
        state_d     = Done ? S_ADV : S_WAIT;
      end
      S_WAIT: begin
        Busy = 1'b1;
        if (Done) begin
          state_d = S_ADV;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ADV: begin
        // Memory is write-protected while Busy, so cur_word is still the
        // instruction just completed.
        Busy  = 1'b1;
        cnt_d = '0;
        if (advance) begin
          pc_d    = pc_q + (cur_is_mvi ? ADDR_W'(2) : ADDR_W'(1));
          state_d = S_ISSUE;
        end
      end
      S_HALT: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PC        = pc_q;
  assign Error     = error_q;
  assign dbg_state = state_q;

endmodule
